// File: rtl/sevseg_pkg.sv
// ============================================================================
// Module   : sevseg_pkg
// Brief    : Shared constants and types for the seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sevseg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low a..g patterns, entry 15 first so c_FONT[n] is the glyph for hex n.
    localparam logic [15:0][6:0] c_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [0:0] {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sevseg_font_dec.sv
// ============================================================================
// Module   : sevseg_font_dec
// Brief    : Combinational hex digit to active-low seven-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevseg_font_dec
    import sevseg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_FONT[i_digit];
    end

endmodule

`default_nettype wire

// File: rtl/sevseg_scan_driver.sv
// ============================================================================
// Module   : sevseg_scan_driver
// Brief    : Time-multiplexed N-digit common-anode display driver with guard
//            gaps and tear-free frame updates. SEVSEG_LZ_BLANK_EN enables
//            leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dots,
    input  logic                    enable,
    output logic                    pending,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GUARD    = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    state_t                  r_state;
    logic [4*NUM_DIGITS-1:0] r_shown_val;
    logic [NUM_DIGITS-1:0]   r_shown_dots;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dots;
    logic                    r_pending;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_wrap;
    logic                    w_apply;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [IDX_W-1:0]        w_idx_nxt;
    state_t                  w_state_nxt;
    logic [3:0]              w_digit;
    logic                    w_dot;
    logic [6:0]              w_font;
    logic [6:0]              w_seg7;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    // State follows the counter so GUARD always covers the first GUARD_CYCLES of a slot.
    always_comb begin
        w_wrap      = (r_cnt == c_CNT_LAST);
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt   = r_idx;
        if (w_wrap) begin
            w_idx_nxt = (r_idx == c_IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end
        w_state_nxt = (w_cnt_nxt < c_GUARD) ? GUARD : DRIVE;
        w_apply     = w_wrap && (r_idx == c_IDX_LAST) && r_pending;
    end

    always_comb begin
        w_digit = r_shown_val[{r_idx, 2'b00} +: 4];
        w_dot   = r_shown_dots[r_idx];
    end

    sevseg_font_dec u_font_dec (
        .i_digit (w_digit),
        .o_seg   (w_font)
    );

`ifdef SEVSEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_zero_run;

    // A digit blanks only while everything from it upward is a dot-less zero.
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run & (r_shown_val[4*k +: 4] == 4'h0) & ~r_shown_dots[k];
            w_blank[k] = w_zero_run;
        end
        w_seg7 = w_blank[r_idx] ? 7'h7F : w_font;
    end
`else
    always_comb begin
        w_seg7 = w_font;
    end
`endif

    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_OFF;
        if ((r_state == DRIVE) && enable) begin
            w_an_nxt  = ~(NUM_DIGITS'(1) << r_idx);
            w_seg_nxt = {~w_dot, w_seg7};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_state      <= GUARD;
            r_shown_val  <= '0;
            r_shown_dots <= '0;
            r_pend_val   <= '0;
            r_pend_dots  <= '0;
            r_pending    <= 1'b0;
            r_seg        <= SEG_OFF;
            r_an         <= '1;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_state_nxt;
            r_seg   <= w_seg_nxt;
            r_an    <= w_an_nxt;
            if (w_apply) begin
                r_shown_val  <= r_pend_val;
                r_shown_dots <= r_pend_dots;
                r_pending    <= 1'b0;
            end
            // A coincident load refills the pending slot after the old one was applied.
            if (load) begin
                r_pend_val  <= value;
                r_pend_dots <= dots;
                r_pending   <= 1'b1;
            end
        end
    end

    assign pending = r_pending;
    assign seg     = r_seg;
    assign an      = r_an;

endmodule

`default_nettype wire

// File: tb/tb_sevseg_scan_driver.sv
// ============================================================================
// Module   : tb_sevseg_scan_driver
// Brief    : Self-checking bench for sevseg_scan_driver (4 digits, 8-cycle
//            slots, 2-cycle guard); honours SEVSEG_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sevseg_scan_driver;

    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int GUARD = 2;

    logic          clk;
    logic          rst;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dots;
    logic          enable;
    logic          pending;
    logic [7:0]    seg;
    logic [3:0]    an;

    sevseg_scan_driver #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SLOT),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .value   (value),
        .dots    (dots),
        .enable  (enable),
        .pending (pending),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       pend;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state.
    int          m_cnt, m_idx;
    bit          m_drive;
    logic [15:0] m_sv, m_pv;
    logic [3:0]  m_sd, m_pd;
    bit          m_pending;

    bit          cap_en;
    logic [7:0]  cap_seg [4];
    int          cap_cnt [4];
    int          cap_off;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] m_glyph(input int k);
        logic [6:0] g;
        g = font(m_sv[4*k +: 4]);
`ifdef SEVSEG_LZ_BLANK_EN
        if (k >= 1) begin
            bit z;
            z = 1'b1;
            for (int j = k; j < ND; j++)
                if (m_sv[4*j +: 4] != 4'h0 || m_sd[j]) z = 1'b0;
            if (z) g = 7'h7F;
        end
`endif
        return g;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_drive = 1'b0;
        m_sv = '0; m_sd = '0; m_pv = '0; m_pd = '0; m_pending = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: push what the DUT must show after this edge, then pop and compare.
    task automatic cyc();
        exp_t e;
        bit   wrap;
        if (rst) begin
            e.an = 4'hF; e.seg = 8'hFF;
            model_reset();
        end else begin
            if (m_drive && enable) begin
                e.an  = ~(4'b0001 << m_idx);
                e.seg = {~m_sd[m_idx], m_glyph(m_idx)};
            end else begin
                e.an = 4'hF; e.seg = 8'hFF;
            end
            wrap = (m_cnt == SLOT - 1);
            if (wrap && m_idx == ND - 1 && m_pending) begin
                m_sv = m_pv; m_sd = m_pd; m_pending = 1'b0;
            end
            if (load) begin
                m_pv = value; m_pd = dots; m_pending = 1'b1;
            end
            m_cnt = wrap ? 0 : m_cnt + 1;
            if (wrap) m_idx = (m_idx + 1) % ND;
            m_drive = (m_cnt >= GUARD);
        end
        e.pend = m_pending;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("pending", 32'(pending), 32'(e.pend));
        if (cap_en) begin
            if (an == 4'hF) cap_off++;
            for (int i = 0; i < ND; i++)
                if (an == ~(4'b0001 << i)) begin
                    cap_seg[i] = seg;
                    cap_cnt[i]++;
                end
        end
    endtask

    task automatic run_until_applied();
        for (int i = 0; i < 80 && m_pending; i++) cyc();
    endtask

    task automatic capture_frame();
        for (int i = 0; i < ND; i++) begin
            cap_seg[i] = 8'hxx; cap_cnt[i] = 0;
        end
        cap_off = 0;
        cap_en  = 1'b1;
        repeat (ND * SLOT) cyc();
        cap_en  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dots = '0; enable = 1'b1; cap_en = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) cyc();
        chk("rst_seg", 32'(seg), 32'h0000_00FF);
        chk("rst_an", 32'(an), 32'h0000_000F);
        chk("rst_pending", 32'(pending), 32'h0);
        rst = 1'b0;
        repeat (3) cyc();
        chk("first_drive_an", 32'(an), 32'h0000_000E);
        chk("first_drive_seg", 32'(seg), 32'h0000_00C0);
        repeat (30) cyc();

        // Frame 12AF with dot on digit 1; the guard gap must hold in every slot.
        value = 16'h12AF; dots = 4'b0010; load = 1'b1;
        cyc();
        load = 1'b0;
        chk("load_pending", 32'(pending), 32'h1);
        run_until_applied();
        capture_frame();
        chk("f1_d0", 32'(cap_seg[0]), 32'h8E);
        chk("f1_d1", 32'(cap_seg[1]), 32'h08);
        chk("f1_d2", 32'(cap_seg[2]), 32'hA4);
        chk("f1_d3", 32'(cap_seg[3]), 32'hF9);
        for (int i = 0; i < ND; i++) chk("f1_active_cycles", 32'(cap_cnt[i]), 32'd6);
        chk("f1_guard_cycles", 32'(cap_off), 32'd8);

        // Two loads within one frame: the last one wins.
        for (int i = 0; i < 40 && !(m_idx == 0 && m_cnt == 0); i++) cyc();
        value = 16'h1111; dots = 4'b0000; load = 1'b1;
        cyc();
        load = 1'b0;
        repeat (5) cyc();
        value = 16'h2222; load = 1'b1;
        cyc();
        load = 1'b0;
        run_until_applied();
        capture_frame();
        for (int i = 0; i < ND; i++) chk("last_load_wins", 32'(cap_seg[i]), 32'hA4);

        // Display dark while the scan keeps running.
        enable = 1'b0;
        repeat (20) cyc();
        chk("dark_an", 32'(an), 32'h0000_000F);
        enable = 1'b1;
        repeat (40) cyc();

        // Reset pulse during digit 2 DRIVE with a frame still pending.
        for (int i = 0; i < 40 && !(m_idx == 0 && m_cnt == 0); i++) cyc();
        value = 16'h3456; dots = 4'b1111; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 40 && !(m_drive && m_idx == 2); i++) cyc();
        cyc();
        chk("pre_rst_pending", 32'(pending), 32'h1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_seg", 32'(seg), 32'h0000_00FF);
        chk("mid_rst_an", 32'(an), 32'h0000_000F);
        chk("mid_rst_pending", 32'(pending), 32'h0);
        repeat (40) cyc();

        // Leading zeros: 0050 with no dots.
        value = 16'h0050; dots = 4'b0000; load = 1'b1;
        cyc();
        load = 1'b0;
        run_until_applied();
        capture_frame();
`ifdef SEVSEG_LZ_BLANK_EN
        chk("lz_d3", 32'(cap_seg[3]), 32'hFF);
        chk("lz_d2", 32'(cap_seg[2]), 32'hFF);
`else
        chk("lz_d3", 32'(cap_seg[3]), 32'hC0);
        chk("lz_d2", 32'(cap_seg[2]), 32'hC0);
`endif
        chk("lz_d1", 32'(cap_seg[1]), 32'h92);
        chk("lz_d0", 32'(cap_seg[0]), 32'hC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
